// File: rtl/fir_tap_sequencer.sv
// Sequential FIR filter: one tap per cycle through an external multiply-add, with valid/ready handshakes.
// Optional FIR_SATURATE_EN clamps the shifted accumulator to the DATA_W range instead of wrapping.
module fir_tap_sequencer #(
  parameter int NTAPS     = 8,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_data,
  input  logic                     coef_we,
  input  logic              [5:0]  coef_addr,
  input  logic signed [DATA_W-1:0] coef_wdata,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  output logic signed [ACC_W-1:0]  mac_din,
  input  logic signed [ACC_W-1:0]  mac_c
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  delay [NTAPS];
  logic signed [DATA_W-1:0]  coef  [NTAPS];
  logic signed [ACC_W-1:0]   acc;
  logic        [IW-1:0]      idx;
  logic        [DATA_W-1:0]  result;
  logic                      coef_hit;

  assign in_ready = (state == IDLE);
  assign coef_hit = coef_we && ({1'b0, coef_addr} < 7'(NTAPS));

  assign mac_a   = (state == MAC) ? delay[idx] : '0;
  assign mac_b   = (state == MAC) ? coef[idx]  : '0;
  assign mac_din = (state == MAC) ? acc        : '0;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> OUT_SHIFT;

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)
      result = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN)
      result = SAT_MIN[DATA_W-1:0];
  end
`else
  always_comb begin
    result = DATA_W'(acc >>> OUT_SHIFT);
  end
`endif

  // OUT spends one cycle latching the result before raising out_valid, so data is stable from the first valid cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        delay[k] <= '0;
        coef[k]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_hit)
            coef[coef_addr[IW-1:0]] <= coef_wdata;
          if (in_valid) begin
            delay[0] <= in_data;
            for (int k = 1; k < NTAPS; k++)
              delay[k] <= delay[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= mac_c;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= OUT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: two instances (OUT_SHIFT 0 and 15, NTAPS 4) share inputs.
// Expected values are hand-computed; the combinational multiply-add is modelled here.
module tb_fir_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        coef_we = 1'b0;
  logic [5:0]  coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [15:0] out_data_a, out_data_b;
  logic signed [15:0] mac_a_a, mac_b_a, mac_a_b, mac_b_b;
  logic signed [31:0] mac_din_a, mac_c_a, mac_din_b, mac_c_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign mac_c_a = mac_a_a * mac_b_a + mac_din_a;
  assign mac_c_b = mac_a_b * mac_b_b + mac_din_b;

  fir_tap_sequencer #(.NTAPS(4), .DATA_W(16), .ACC_W(32), .OUT_SHIFT(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .mac_a(mac_a_a), .mac_b(mac_b_a), .mac_din(mac_din_a), .mac_c(mac_c_a)
  );

  fir_tap_sequencer #(.NTAPS(4), .DATA_W(16), .ACC_W(32), .OUT_SHIFT(15)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .mac_a(mac_a_b), .mac_b(mac_b_b), .mac_din(mac_din_b), .mac_c(mac_c_b)
  );

  typedef struct {
    logic signed [15:0] din;
    logic [15:0]        exp_a;
    logic [15:0]        exp_b;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic signed [15:0] data);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = addr; coef_wdata = data;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Transfers one sample; returns after the transfer edge (+1).
  task automatic start_sample(input logic signed [15:0] d);
    @(negedge clk);
    check("in_ready_before_transfer", {31'b0, in_ready_a}, 32'd1);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the transfer edge until out_valid is seen; poke drives a coefficient write during MAC.
  task automatic wait_output(input bit poke, output int lat);
    lat = 0;
    if (poke) begin
      coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'sd7;
      @(posedge clk); #1;
      lat++;
      coef_we = 1'b0;
    end
    while (!out_valid_a && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_latency", lat, 32'd5);
    check("out_valid_b_with_a", {31'b0, out_valid_b}, 32'd1);
  endtask

  task automatic accept_output;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_accept", {31'b0, out_valid_a}, 32'd0);
    check("in_ready_after_accept", {31'b0, in_ready_a}, 32'd1);
  endtask

  task automatic applyStimulus(input logic signed [15:0] d, input bit poke,
                               output logic [15:0] ya, output logic [15:0] yb);
    int lat;
    start_sample(d);
    wait_output(poke, lat);
    ya = out_data_a;
    yb = out_data_b;
    accept_output();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] ya, input logic [15:0] yb,
                             input logic [15:0] ea, input logic [15:0] eb);
    check({name, "_a"}, {16'b0, ya}, {16'b0, ea});
    check({name, "_b"}, {16'b0, yb}, {16'b0, eb});
  endtask

  initial begin
    logic [15:0] ya, yb, held;
    int seen;

    vecs[0] = '{din: 16'sd5,  exp_a: 16'd5,      exp_b: 16'd0};
    vecs[1] = '{din: 16'sd0,  exp_a: 16'd10,     exp_b: 16'd0};
    vecs[2] = '{din: 16'sd0,  exp_a: 16'd15,     exp_b: 16'd0};
    vecs[3] = '{din: 16'sd0,  exp_a: 16'd20,     exp_b: 16'd0};
    vecs[4] = '{din: 16'sd0,  exp_a: 16'd0,      exp_b: 16'd0};
    vecs[5] = '{din: -16'sd2, exp_a: 16'hFFFE,   exp_b: 16'hFFFF};
    vecs[6] = '{din: 16'sd3,  exp_a: 16'hFFFF,   exp_b: 16'hFFFF};
    vecs[7] = '{din: 16'sd1,  exp_a: 16'd1,      exp_b: 16'd0};
    vecs[8] = '{din: 16'sd0,  exp_a: 16'd3,      exp_b: 16'd0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready_a}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("reset_out_data", {16'b0, out_data_a}, 32'd0);
    check("reset_mac_a", {16'b0, mac_a_a}, 32'd0);
    check("reset_mac_b", {16'b0, mac_b_a}, 32'd0);
    check("reset_mac_din", mac_din_a, 32'd0);

    // Impulse and mixed-sign vectors through coefficients {1,2,3,4}
    for (int i = 0; i < 4; i++) write_coef(6'(i), 16'(i + 1));
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].din, 1'b0, ya, yb);
      checkOutput($sformatf("vec%0d", i), ya, yb, vecs[i].exp_a, vecs[i].exp_b);
    end

    // Q15 half-gain tap
    write_coef(6'd0, 16'sh4000);
    for (int i = 1; i < 4; i++) write_coef(6'(i), 16'sd0);
    applyStimulus(16'sd1000, 1'b0, ya, yb);
    checkOutput("q15", ya, yb, 16'd0, 16'd500);

    // Overflow of the 16-bit output
    write_coef(6'd0, 16'sd1000);
    applyStimulus(16'sd1000, 1'b0, ya, yb);
`ifdef FIR_SATURATE_EN
    checkOutput("overflow", ya, yb, 16'd32767, 16'd30);
`else
    checkOutput("overflow", ya, yb, 16'd16960, 16'd30);
`endif

    // Backpressure: ten cycles with out_ready low
    begin
      int lat;
      start_sample(16'sd7);
      wait_output(1'b0, lat);
      held = out_data_a;
      check("bp_first_data", {16'b0, held}, 32'd7000);
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check("bp_out_valid", {31'b0, out_valid_a}, 32'd1);
        check("bp_out_data", {16'b0, out_data_a}, {16'b0, held});
        check("bp_in_ready", {31'b0, in_ready_a}, 32'd0);
      end
      accept_output();
    end

    // Dropped writes: one during MAC, one to an out-of-range address
    applyStimulus(16'sd3, 1'b1, ya, yb);
    checkOutput("drop_first", ya, yb, 16'd3000, 16'd0);
    write_coef(6'd9, 16'sd55);
    applyStimulus(16'sd2, 1'b0, ya, yb);
    checkOutput("drop_second", ya, yb, 16'd2000, 16'd0);

    // Reset two cycles into MAC
    for (int i = 0; i < 4; i++) write_coef(6'(i), 16'(i + 1));
    start_sample(16'sd5);
    check("mac_a_tap0", {16'b0, mac_a_a}, 32'd5);
    check("mac_b_tap0", {16'b0, mac_b_a}, 32'd1);
    check("mac_din_tap0", mac_din_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midmac_reset_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("midmac_reset_mac_a", {16'b0, mac_a_a}, 32'd0);
    check("midmac_reset_mac_din", mac_din_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid_a || out_valid_b) seen++;
    end
    check("midmac_no_output", seen, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0 ? 16'sd5 : 16'sd0, 1'b0, ya, yb);
      checkOutput($sformatf("post_reset%0d", i), ya, yb, 16'd0, 16'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 8, number of filter taps (2..64).
REQ-002 SHALL have parameter DATA_W, default 16, sample/coefficient width (signed).
REQ-003 SHALL have parameter ACC_W, default 32, accumulator width (signed).
REQ-004 SHALL have parameter OUT_SHIFT, default 15, arithmetic right shift applied to accumulator for output (Q15 coefficients).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_W: sample handshake.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_W: filtered sample handshake.
REQ-009 SHALL have ports coef_we input 1, coef_addr input 6, coef_wdata input DATA_W: coefficient write port.
REQ-010 SHALL have ports mac_a output DATA_W, mac_b output DATA_W, mac_din output ACC_W, mac_c input ACC_W: drive an external combinational multiply-add (mac_c = mac_a*mac_b + mac_din, signed).

Function
REQ-011 SHALL implement FSM states IDLE, MAC, OUT.
REQ-012 SHALL assert in_ready only in IDLE; transfer occurs on in_valid && in_ready at a rising edge.
REQ-013 SHALL on transfer shift in_data into delay line position 0 (position k moves to k+1, oldest dropped), clear acc to 0, set tap index to 0, enter MAC.
REQ-014 SHALL in MAC drive mac_a = delay[idx], mac_b = coef[idx], mac_din = acc; at each edge acc <= mac_c, idx <= idx+1.
REQ-015 SHALL leave MAC for OUT on the edge where idx == NTAPS-1 (exactly NTAPS MAC cycles).
REQ-016 SHALL drive mac_a, mac_b, mac_din to 0 outside MAC.
REQ-017 SHALL assert out_valid only in OUT; first out_valid cycle is NTAPS+1 edges after the input transfer edge.
REQ-018 SHALL drive out_data = low DATA_W bits (or saturated, see REQ-024) of acc >>> OUT_SHIFT, stable while out_valid high.
REQ-019 SHALL return to IDLE on out_valid && out_ready; no new input accepted in the same cycle (one bubble).
REQ-020 SHALL write coef[coef_addr] <= coef_wdata on coef_we only in IDLE and only when coef_addr < NTAPS; writes in MAC/OUT or to out-of-range addresses are silently dropped.
REQ-021 SHALL hold out_valid and out_data indefinitely under backpressure (out_ready low) with in_ready low.

Reset
REQ-022 SHALL on reset asynchronously force state IDLE, acc 0, idx 0, all delay-line entries 0, all coefficients 0.
REQ-023 SHALL on reset drive in_ready 1 (after reset release), out_valid 0, out_data 0, mac_a/mac_b/mac_din 0; reset mid-MAC or mid-OUT discards the result with no output.

Configuration
REQ-024 SHALL with FIR_SATURATE_EN defined clamp acc >>> OUT_SHIFT to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before out_data; without it, out_data is the plain low DATA_W bits (wrap).

Verification (NTAPS=4, DATA_W=16, ACC_W=32, OUT_SHIFT=0 unless stated)
REQ-025 SHALL cover impulse: coefs {1,2,3,4}, inputs 5,0,0,0,0 -> out_data 5,10,15,20,0.
REQ-026 SHALL cover latency/Q15: OUT_SHIFT=15, coef[0]=16'h4000, others 0, in_data 1000 -> out_valid 5 edges after transfer, out_data 500.
REQ-027 SHALL cover overflow: coef[0]=1000, in_data 1000 -> out_data 32767 with FIR_SATURATE_EN, 16960 (16'h4240) without.
REQ-028 SHALL cover backpressure: out_ready low 10 cycles -> out_valid held, out_data constant, in_ready 0; out_ready high -> IDLE next edge, in_ready 1.
REQ-029 SHALL cover dropped write: coef_we with coef_addr 0, wdata 7 during MAC, and addr 9 in IDLE -> coefficients unchanged, next output unaffected.
REQ-030 SHALL cover reset mid-MAC: reset asserted 2 cycles into MAC -> out_valid never asserted, delay line and coefs read back 0 (impulse after reset gives all-zero outputs).
